// File: rtl/riscv_id_stage.sv
// RISC-V decode stage: register file, control and immediate decode,
// load-use hazard detection and the ID/EX pipeline register.
module riscv_id_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit WB_BYPASS  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [31:0]           i_instr_d,
  input  logic [XLEN-1:0]       i_pc_d,
  input  logic                  i_valid_d,
  input  logic                  i_flush_e,
  input  logic [XLEN-1:0]       i_result_w,
  input  logic                  i_reg_write_w,
  input  logic [REG_ADDR_W-1:0] i_rd_w,
  output logic                  o_stall_d,
  output logic                  o_valid_e,
  output logic [1:0]            o_result_src_e,
  output logic                  o_alu_src_a_e,
  output logic                  o_alu_src_b_e,
  output logic                  o_reg_write_e,
  output logic                  o_mem_write_e,
  output logic                  o_jalr_e,
  output logic                  o_jump_e,
  output logic                  o_branch_e,
  output logic                  o_zero_condition_e,
  output logic [3:0]            o_mem_byte_sel_e,
  output logic [3:0]            o_alu_control_e,
  output logic [XLEN-1:0]       o_rd1_e,
  output logic [XLEN-1:0]       o_rd2_e,
  output logic [XLEN-1:0]       o_extimm_e,
  output logic [XLEN-1:0]       o_pc_e,
  output logic [REG_ADDR_W-1:0] o_rs1_e,
  output logic [REG_ADDR_W-1:0] o_rs2_e,
  output logic [REG_ADDR_W-1:0] o_rd_e,
  output logic                  o_illegal_reg_e
);

  localparam int NREG = 1 << REG_ADDR_W;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU code is {instr[30], funct3}; LUI uses a dedicated pass-B code
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            result_src;
    logic                  alu_src_a;
    logic                  alu_src_b;
    logic                  reg_write;
    logic                  mem_write;
    logic                  jalr;
    logic                  jump;
    logic                  branch;
    logic                  zero_cond;
    logic [3:0]            byte_sel;
    logic [3:0]            alu_ctrl;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  illegal;
  } idex_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:0])
      OP_I, OP_LOAD, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:               imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:              imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:       imm = {ins[31:12], 12'd0};
      OP_JAL:                 imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:                imm = 32'd0;
    endcase
    return imm;
  endfunction

  // Byte lanes by access size; the EX stage shifts them by the address
  function automatic logic [3:0] byte_sel(input logic [2:0] f3);
    logic [3:0] sel;
    case (f3[1:0])
      2'b00:   sel = 4'b0001;
      2'b01:   sel = 4'b0011;
      2'b10:   sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  logic [XLEN-1:0]       rf_q [NREG];
  logic [REG_ADDR_W-1:0] rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0]       rd1_s, rd2_s;
  logic                  wb_en_s, illegal_s, stall_s;
  logic [6:0]            opcode_s;
  logic [2:0]            funct3_s;
  idex_t                 dec_s, idex_d, idex_q;

  assign rs1_s    = i_instr_d[15 +: REG_ADDR_W];
  assign rs2_s    = i_instr_d[20 +: REG_ADDR_W];
  assign rd_s     = i_instr_d[7 +: REG_ADDR_W];
  assign opcode_s = i_instr_d[6:0];
  assign funct3_s = i_instr_d[14:12];
  assign wb_en_s  = i_reg_write_w && (i_rd_w != '0);

  assign rd1_s = (rs1_s == '0) ? '0 :
                 (WB_BYPASS && wb_en_s && (i_rd_w == rs1_s)) ? i_result_w : rf_q[rs1_s];
  assign rd2_s = (rs2_s == '0) ? '0 :
                 (WB_BYPASS && wb_en_s && (i_rd_w == rs2_s)) ? i_result_w : rf_q[rs2_s];

  // Top index bits cannot be represented in a reduced (RV32E) file
  assign illegal_s = (REG_ADDR_W < 5) && (i_instr_d[19] || i_instr_d[24] || i_instr_d[11]);

  assign stall_s = i_valid_d && idex_q.valid && idex_q.reg_write &&
                   (idex_q.result_src == 2'b01) && (idex_q.rd != '0) &&
                   ((idex_q.rd == rs1_s) || (idex_q.rd == rs2_s));

  // Register file write port; entry 0 is never written
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en_s) begin
      rf_q[i_rd_w] <= i_result_w;
    end
  end

  // Control and operand decode of the instruction in the decode slot
  always_comb begin
    dec_s         = '0;
    dec_s.valid   = 1'b1;
    dec_s.rd1     = rd1_s;
    dec_s.rd2     = rd2_s;
    dec_s.imm     = XLEN'($signed(imm_gen(i_instr_d)));
    dec_s.pc      = i_pc_d;
    dec_s.rs1     = rs1_s;
    dec_s.rs2     = rs2_s;
    dec_s.rd      = rd_s;
    dec_s.illegal = illegal_s;
    case (opcode_s)
      OP_R: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_ctrl  = {i_instr_d[30], funct3_s};
      end
      OP_I: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src_b = 1'b1;
        dec_s.alu_ctrl  = (funct3_s == 3'b101) ? {i_instr_d[30], funct3_s} : {1'b0, funct3_s};
      end
      OP_LOAD: begin
        dec_s.reg_write  = 1'b1;
        dec_s.alu_src_b  = 1'b1;
        dec_s.result_src = 2'b01;
        dec_s.byte_sel   = byte_sel(funct3_s);
      end
      OP_STORE: begin
        dec_s.mem_write = 1'b1;
        dec_s.alu_src_b = 1'b1;
        dec_s.byte_sel  = byte_sel(funct3_s);
      end
      OP_BRANCH: begin
        dec_s.branch    = 1'b1;
        dec_s.alu_ctrl  = funct3_s[2] ? (funct3_s[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        // Taken when the ALU result is zero: beq, bge, bgeu
        dec_s.zero_cond = (funct3_s == 3'b000) || (funct3_s[2] && funct3_s[0]);
      end
      OP_JAL: begin
        dec_s.jump       = 1'b1;
        dec_s.reg_write  = 1'b1;
        dec_s.result_src = 2'b10;
        dec_s.alu_src_a  = 1'b1;
        dec_s.alu_src_b  = 1'b1;
      end
      OP_JALR: begin
        dec_s.jalr       = 1'b1;
        dec_s.jump       = 1'b1;
        dec_s.reg_write  = 1'b1;
        dec_s.result_src = 2'b10;
        dec_s.alu_src_b  = 1'b1;
      end
      OP_LUI: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src_b = 1'b1;
        dec_s.alu_ctrl  = ALU_LUI;
      end
      OP_AUIPC: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src_a = 1'b1;
        dec_s.alu_src_b = 1'b1;
      end
      default: dec_s.alu_ctrl = ALU_ADD;
    endcase
    dec_s.reg_write = dec_s.reg_write && !illegal_s;
    dec_s.mem_write = dec_s.mem_write && !illegal_s;
  end

  // ID/EX next state: flush, then stall, then empty slot insert a bubble
  always_comb begin
    idex_d = '0;
    if (i_flush_e) begin
      idex_d = '0;
    end else if (stall_s) begin
      idex_d = '0;
    end else if (!i_valid_d) begin
      idex_d = '0;
    end else begin
      idex_d = dec_s;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) idex_q <= '0;
    else         idex_q <= idex_d;
  end

  assign o_stall_d          = stall_s;
  assign o_valid_e          = idex_q.valid;
  assign o_result_src_e     = idex_q.result_src;
  assign o_alu_src_a_e      = idex_q.alu_src_a;
  assign o_alu_src_b_e      = idex_q.alu_src_b;
  assign o_reg_write_e      = idex_q.reg_write;
  assign o_mem_write_e      = idex_q.mem_write;
  assign o_jalr_e           = idex_q.jalr;
  assign o_jump_e           = idex_q.jump;
  assign o_branch_e         = idex_q.branch;
  assign o_zero_condition_e = idex_q.zero_cond;
  assign o_mem_byte_sel_e   = idex_q.byte_sel;
  assign o_alu_control_e    = idex_q.alu_ctrl;
  assign o_rd1_e            = idex_q.rd1;
  assign o_rd2_e            = idex_q.rd2;
  assign o_extimm_e         = idex_q.imm;
  assign o_pc_e             = idex_q.pc;
  assign o_rs1_e            = idex_q.rs1;
  assign o_rs2_e            = idex_q.rs2;
  assign o_rd_e             = idex_q.rd;
  assign o_illegal_reg_e    = idex_q.illegal;

endmodule
